pe_ctrl_gen: RTL and testbench
==============================

Name: pe_ctrl_gen

Overview:
- Parametrised control unit for one convolution processing element (PE).
- Sequences, per output pixel: accumulator clear, MAC_LEN multiply-accumulate cycles, load of the result into a packed result word, and the write of that word to output memory.
- Generalises the fixed 16-tap / 4-result / 16x16 PE controller to arbitrary kernel length, packing factor, image/kernel size and image count.
- Adds a MAC stall input, partial-word flush at image end and multi-image sequencing; sits between the PE datapath (buffers, accumulator, result register) and the output memory.

Parameters:
- MAC_LEN, 16, MAC cycles per output pixel (kernel taps).
- RES_PER_WORD, 4, results packed per output memory word.
- IMG_SIZE, 16, input image side length.
- KER_SIZE, 4, kernel side length; OUT_W = IMG_SIZE-KER_SIZE+1.
- NUM_IMAGES, 1, images processed per start.
- CW, 8, width of all counters/indices; must hold max(MAC_LEN, IMG_SIZE*IMG_SIZE, total words, NUM_IMAGES).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin run; sampled only in IDLE.
- stall  in  1  datapath not ready; freezes MAC progress.
- busy  out  1  high in every state except IDLE.
- init_clr  out  1  datapath clear, INIT only.
- acc_en  out  1  accumulate this cycle.
- acc_clr  out  1  clear accumulator.
- res_ld  out  1  load accumulator into res_idx slot.
- res_clr  out  1  clear result word register.
- wr_en  out  1  write result word at wr_adr.
- wr_file  out  1  dump output memory (DONE).
- done  out  1  one-cycle completion pulse.
- buf_cntr  out  CW  current MAC tap index.
- img_idx  out  CW  top-left input index of current window.
- res_idx  out  CW  slot within current result word.
- wr_adr  out  CW  output memory word address.
- img_num  out  CW  current image number.

Behaviour:
- Controls are Moore outputs decoded from state; counters are registered and presented directly. All outputs and counters reset to 0; state resets to IDLE.
- rst during any state: next edge enters IDLE with everything 0; no further wr_en.
- IDLE: start=1 -> INIT. Counters hold their last values until INIT.
- INIT (1 cycle): init_clr=1; buf_cntr, img_idx, col, res_idx, wr_adr, img_num <= 0 -> MAC. col is an internal column counter, 0..OUT_W-1.
- MAC: acc_en = !stall.
  - If !stall, buf_cntr++. When buf_cntr==MAC_LEN-1 and !stall, buf_cntr <= 0 and go to LD_RESULT.
  - With stall=1, state and all counters are frozen.
- LD_RESULT (1 cycle): res_ld=1, acc_clr=1; res_idx++.
  - If col==OUT_W-1: col <= 0, img_idx += KER_SIZE (row skip). Else col++, img_idx++.
  - last_pix = (img_idx==(OUT_W-1)*(IMG_SIZE+1)) before the update.
  - Go to WRITE_MEM if res_idx==RES_PER_WORD-1 or last_pix; else MAC.
- WRITE_MEM (1 cycle): wr_en=1, res_clr=1, wr_adr presents the current address; then wr_adr++, res_idx <= 0.
  - last_pix and img_num==NUM_IMAGES-1 -> DONE.
  - last_pix otherwise -> NEXT_IMG.
  - else -> MAC.
- A partial word (fewer than RES_PER_WORD results) is flushed at image end; unused slots are not cleared beyond res_clr.
- NEXT_IMG (1 cycle): img_num++, img_idx <= 0, col <= 0, res_idx <= 0. wr_adr is NOT reset; images are stored contiguously. -> MAC.
- DONE (1 cycle): done=1, wr_file=1 -> IDLE.
- start is ignored while busy. stall is ignored outside MAC. start held high at DONE->IDLE restarts on the next cycle.
- Latency: MAC_LEN+1 cycles per pixel, plus 1 per word write, plus 1 per image change, plus 2 (INIT, DONE).
- Words per image = ceil(OUT_W*OUT_W / RES_PER_WORD).

Test Plan:
- Defaults, single start pulse, stall=0:
  - Exactly 169 res_ld pulses and 43 wr_en pulses, with wr_adr 0..42.
  - The final write follows 1 result (partial word).
  - done is high in cycle 2918, counting INIT as cycle 1, for one cycle, together with wr_file.
- Row skip, defaults: img_idx is 0,1,..,12 then 16 after the 13th LD_RESULT. After the 26th LD_RESULT it is 32.
- Stall: assert stall for 5 cycles mid-MAC at buf_cntr=7. buf_cntr holds 7, acc_en=0 throughout, and pixel latency grows by exactly 5 cycles.
- Multi-image, NUM_IMAGES=2, IMG_SIZE=6, KER_SIZE=3, RES_PER_WORD=4:
  - 16 pixels per image, 4 words per image, no partial word.
  - NEXT_IMG visited once; img_num 0->1; wr_adr runs 0..7 without reset.
  - done once, after 2*(16*17+4)+1+2 cycles.
- Reset mid-run: assert rst during WRITE_MEM of word 10. Next cycle all outputs are 0 and state is IDLE. A later start reruns from wr_adr=0.
- start pulsed while busy at cycles 50 and 300: no effect; the total run length is unchanged from the first scenario.

Source files
------------

// File: rtl/pe_ctrl_if.sv
// pe_ctrl_if: PE controller bundle; master drives busy/strobes/counters, slave drives start/stall
interface pe_ctrl_if #(parameter int CW = 8);
  logic start, stall, busy, init_clr, acc_en, acc_clr, res_ld, res_clr, wr_en, wr_file, done;
  logic [CW-1:0] buf_cntr, img_idx, res_idx, wr_adr, img_num;
  modport master(
    input start, stall,
    output busy, init_clr, acc_en, acc_clr, res_ld, res_clr, wr_en, wr_file, done,
    output buf_cntr, img_idx, res_idx, wr_adr, img_num
  );
  modport slave(
    output start, stall,
    input busy, init_clr, acc_en, acc_clr, res_ld, res_clr, wr_en, wr_file, done,
    input buf_cntr, img_idx, res_idx, wr_adr, img_num
  );
endinterface

// File: rtl/pe_ctrl_gen.sv
// pe_ctrl_gen: convolution PE sequencer (clk, rst, bus: start/stall in; busy, strobes, tap/window/slot/address/image counters out)
module pe_ctrl_gen #(
  parameter int MAC_LEN = 16,
  parameter int RES_PER_WORD = 4,
  parameter int IMG_SIZE = 16,
  parameter int KER_SIZE = 4,
  parameter int NUM_IMAGES = 1,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst,
  pe_ctrl_if.master bus
);
  localparam int OUT_W = IMG_SIZE - KER_SIZE + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LAST_MAC = CW'(MAC_LEN - 1);
  localparam logic [CW-1:0] LAST_RES = CW'(RES_PER_WORD - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'((OUT_W - 1) * (IMG_SIZE + 1));
  localparam logic [CW-1:0] LAST_IMG = CW'(NUM_IMAGES - 1);
  localparam logic [CW-1:0] ROW_SKIP = CW'(KER_SIZE);
  typedef enum logic [2:0] {IDLE, INIT, MAC, LD_RESULT, WRITE_MEM, NEXT_IMG, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] col;
  logic last_q;
  logic last_pix;
  assign last_pix = bus.img_idx == LAST_IDX;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.buf_cntr <= '0;
      bus.img_idx <= '0;
      bus.res_idx <= '0;
      bus.wr_adr <= '0;
      bus.img_num <= '0;
      col <= '0;
      last_q <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        INIT: begin
          bus.buf_cntr <= '0;
          bus.img_idx <= '0;
          bus.res_idx <= '0;
          bus.wr_adr <= '0;
          bus.img_num <= '0;
          col <= '0;
          last_q <= 1'b0;
        end
        MAC: if (!bus.stall) bus.buf_cntr <= bus.buf_cntr == LAST_MAC ? '0 : bus.buf_cntr + ONE;
        LD_RESULT: begin
          bus.res_idx <= bus.res_idx + ONE;
          last_q <= last_pix;
          col <= col == LAST_COL ? '0 : col + ONE;
          bus.img_idx <= bus.img_idx + (col == LAST_COL ? ROW_SKIP : ONE);
        end
        WRITE_MEM: begin
          bus.wr_adr <= bus.wr_adr + ONE;
          bus.res_idx <= '0;
        end
        NEXT_IMG: begin
          bus.img_num <= bus.img_num + ONE;
          bus.img_idx <= '0;
          bus.res_idx <= '0;
          col <= '0;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? INIT : IDLE;
      INIT: nxt = MAC;
      MAC: nxt = !bus.stall && bus.buf_cntr == LAST_MAC ? LD_RESULT : MAC;
      LD_RESULT: nxt = bus.res_idx == LAST_RES || last_pix ? WRITE_MEM : MAC;
      WRITE_MEM: nxt = !last_q ? MAC : bus.img_num == LAST_IMG ? DONE : NEXT_IMG;
      NEXT_IMG: nxt = MAC;
      default: nxt = IDLE;
    endcase
    bus.busy = state != IDLE;
    bus.init_clr = state == INIT;
    bus.acc_en = state == MAC && !bus.stall;
    bus.acc_clr = state == LD_RESULT;
    bus.res_ld = state == LD_RESULT;
    bus.res_clr = state == WRITE_MEM;
    bus.wr_en = state == WRITE_MEM;
    bus.wr_file = state == DONE;
    bus.done = state == DONE;
  end
endmodule

// File: tb/tb_pe_ctrl_gen.sv
// tb_pe_ctrl_gen: trace-model check of default and multi-image PE controllers under random stall/start
module tb_pe_ctrl_gen;
  typedef struct packed {
    logic busy, init_clr, acc_en, acc_clr, res_ld, res_clr, wr_en, wr_file, done;
    logic [7:0] buf_cntr, img_idx, res_idx, wr_adr, img_num;
  } out_t;
  localparam logic [8:0] C_INIT = 9'h180, C_MAC = 9'h140, C_LD = 9'h130;
  localparam logic [8:0] C_WR = 9'h10C, C_NX = 9'h100, C_DN = 9'h103;
  localparam int ML[2] = '{16, 16};
  localparam int RPW[2] = '{4, 4};
  localparam int IMG[2] = '{16, 6};
  localparam int KER[2] = '{4, 3};
  localparam int NI[2] = '{1, 2};
  logic clk = 0, rst = 1, start = 0, stall = 0;
  bit chk_en = 0;
  int ntot = 0, npass = 0;
  always #5 clk = ~clk;
  pe_ctrl_if #(.CW(8)) ifa ();
  pe_ctrl_if #(.CW(8)) ifb ();
  assign ifa.start = start;
  assign ifa.stall = stall;
  assign ifb.start = start;
  assign ifb.stall = stall;
  pe_ctrl_gen dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  pe_ctrl_gen #(.IMG_SIZE(6), .KER_SIZE(3), .NUM_IMAGES(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
  out_t obs[2];
  assign obs[0] = {ifa.busy, ifa.init_clr, ifa.acc_en, ifa.acc_clr, ifa.res_ld, ifa.res_clr, ifa.wr_en,
                   ifa.wr_file, ifa.done, ifa.buf_cntr, ifa.img_idx, ifa.res_idx, ifa.wr_adr, ifa.img_num};
  assign obs[1] = {ifb.busy, ifb.init_clr, ifb.acc_en, ifb.acc_clr, ifb.res_ld, ifb.res_clr, ifb.wr_en,
                   ifb.wr_file, ifb.done, ifb.buf_cntr, ifb.img_idx, ifb.res_idx, ifb.wr_adr, ifb.img_num};
  out_t q[2][$];
  out_t last[2];
  int cyc[2], dcyc[2], nld[2], nwr[2], lastwa[2], lastri[2], ndone[2], maxim[2];
  int idx13, idx26;
  bit prev_ld[2];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic out_t mk(logic [8:0] c, int bc, int ii, int ri, int wa, int im);
    return out_t'({c, 8'(bc), 8'(ii), 8'(ri), 8'(wa), 8'(im)});
  endfunction
  // whole-run trace from INIT to DONE, one entry per cycle, assuming no stalls
  task automatic gen(int s, out_t h);
    int ow, ii, nii, ri, wa, r, c;
    bit lst;
    ow = IMG[s] - KER[s] + 1;
    ri = 0;
    wa = 0;
    nii = 0;
    q[s].push_back(mk(C_INIT, h.buf_cntr, h.img_idx, h.res_idx, h.wr_adr, h.img_num));
    for (int im = 0; im < NI[s]; im++)
      for (int p = 0; p < ow * ow; p++) begin
        r = p / ow;
        c = p % ow;
        ii = r * IMG[s] + c;
        lst = p == ow * ow - 1;
        for (int k = 0; k < ML[s]; k++) q[s].push_back(mk(C_MAC, k, ii, ri, wa, im));
        q[s].push_back(mk(C_LD, 0, ii, ri, wa, im));
        ri++;
        nii = c == ow - 1 ? (r + 1) * IMG[s] : ii + 1;
        if (ri == RPW[s] || lst) begin
          q[s].push_back(mk(C_WR, 0, nii, ri, wa, im));
          wa++;
          ri = 0;
        end
        if (lst && im < NI[s] - 1) q[s].push_back(mk(C_NX, 0, nii, 0, wa, im));
      end
    q[s].push_back(mk(C_DN, 0, nii, 0, wa, NI[s] - 1));
  endtask
  always @(negedge clk) if (chk_en) for (int s = 0; s < 2; s++) begin
    out_t e;
    bit st, idle;
    idle = q[s].size() == 0;
    e = idle ? last[s] : q[s][0];
    st = e.busy && e.acc_en && stall;
    if (st) e.acc_en = 1'b0;
    chk(s == 0 ? "trace_a" : "trace_b", obs[s], e);
    if (obs[s].init_clr) begin
      cyc[s] = 1; nld[s] = 0; nwr[s] = 0; ndone[s] = 0; maxim[s] = 0; dcyc[s] = 0;
    end else if (obs[s].busy) cyc[s]++;
    if (s == 0 && prev_ld[0] && nld[0] == 13) idx13 = obs[0].img_idx;
    if (s == 0 && prev_ld[0] && nld[0] == 26) idx26 = obs[0].img_idx;
    if (obs[s].res_ld) nld[s]++;
    prev_ld[s] = obs[s].res_ld;
    if (obs[s].wr_en) begin nwr[s]++; lastwa[s] = obs[s].wr_adr; lastri[s] = obs[s].res_idx; end
    if (obs[s].img_num > maxim[s]) maxim[s] = obs[s].img_num;
    if (obs[s].done) begin ndone[s]++; dcyc[s] = cyc[s]; end
    if (!idle && !st) begin
      last[s] = mk(9'h0, e.buf_cntr, e.img_idx, e.res_idx, e.wr_adr, e.img_num);
      void'(q[s].pop_front());
    end
    if (rst) begin q[s].delete(); last[s] = '0; end
    else if (idle && start) gen(s, last[s]);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(int lim);
    int n = 0;
    while ((obs[0].busy || obs[1].busy) && n < lim) begin tick(); n++; end
    if (n >= lim) begin ntot++; $display("FAIL timeout_idle: still busy after %0d cycles", lim); end
  endtask
  task automatic check_full_a(string tag, int len);
    chk({tag, "_len"}, dcyc[0], len);
    chk({tag, "_nld"}, nld[0], 169);
    chk({tag, "_nwr"}, nwr[0], 43);
    chk({tag, "_lastwa"}, lastwa[0], 42);
    chk({tag, "_lastri"}, lastri[0], 1);
    chk({tag, "_ndone"}, ndone[0], 1);
  endtask
  initial begin
    int n;
    last[0] = '0;
    last[1] = '0;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_a", obs[0], 0);
    chk("reset_b", obs[1], 0);
    chk_en = 1;
    // plain run with two ignored start pulses
    start = 1; tick(); start = 0;
    repeat (49) tick();
    start = 1; tick(); start = 0;
    repeat (249) tick();
    start = 1; tick(); start = 0;
    wait_idle(4000);
    check_full_a("run1", 2918);
    chk("run1_idx13", idx13, 16);
    chk("run1_idx26", idx26, 32);
    chk("b_len", dcyc[1], 555);
    chk("b_nwr", nwr[1], 8);
    chk("b_lastwa", lastwa[1], 7);
    chk("b_lastri", lastri[1], 4);
    chk("b_maxim", maxim[1], 1);
    chk("b_ndone", ndone[1], 1);
    // five-cycle stall at tap 7
    start = 1; tick(); start = 0;
    n = 0;
    while (!(obs[0].acc_en && obs[0].buf_cntr == 7) && n < 50) begin tick(); n++; end
    chk("stall_found", n < 50, 1);
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_buf", obs[0].buf_cntr, 7);
      chk("stall_acc", obs[0].acc_en, 0);
    end
    stall = 0;
    wait_idle(4000);
    check_full_a("stall", 2923);
    // random stalls and stray starts while busy
    start = 1; tick(); start = 0;
    for (int i = 0; i < 20000 && (obs[0].busy || obs[1].busy); i++) begin
      stall = $urandom_range(0, 3) == 0;
      start = i < 400 && $urandom_range(0, 99) == 0;
      tick();
    end
    stall = 0;
    start = 0;
    wait_idle(10);
    chk("rand_ndone_a", ndone[0], 1);
    // start held through DONE restarts after one idle cycle
    start = 1;
    n = 0;
    while (!obs[1].done && n < 1000) begin tick(); n++; end
    chk("hold_done_b", obs[1].done, 1);
    tick();
    chk("hold_idle_b", obs[1].busy, 0);
    tick();
    chk("hold_init_b", obs[1].init_clr, 1);
    start = 0;
    // reset during the write of word 10
    n = 0;
    while (!(obs[0].wr_en && obs[0].wr_adr == 10) && n < 4000) begin tick(); n++; end
    chk("rst_found", obs[0].wr_en, 1);
    rst = 1;
    tick();
    chk("rst_mid_a", obs[0], 0);
    chk("rst_mid_b", obs[1], 0);
    rst = 0;
    tick();
    start = 1; tick(); start = 0;
    wait_idle(4000);
    check_full_a("rerun", 2918);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
